// File: rtl/wb_pkg.sv
// Shared constants and the write-back request type for the register write-back path.
package wb_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer holding long-latency write-back requests until the write port is free.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = wb_req_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  entry_t                     push_data_i,
    input  logic                       pop_i,
    output entry_t                     head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-back arbiter: ALU results win, long-latency results drain from a FIFO.
// Define REG_WRITEBACK_BYPASS_EN to let a mem result skip an empty FIFO when the ALU is idle.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = XLEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic [XLEN-1:0]            alu_data_i,
    input  logic                       mem_valid_i,
    output logic                       mem_ready_o,
    input  logic [4:0]                 mem_rd_i,
    input  logic [XLEN-1:0]            mem_data_i,
    input  logic                       issue_valid_i,
    input  logic [4:0]                 issue_rd_i,
    output logic                       wb_regwrite_o,
    output logic [4:0]                 wb_rdaddr_o,
    output logic [XLEN-1:0]            wb_rddata_o,
    output logic [31:0]                busy_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } req_t;

    req_t             fifo_head;
    logic             fifo_full, fifo_empty;
    logic             mem_fire, push, pop, bypass;
    logic             wr_q, wr_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [31:0]      busy_q, busy_d, busy_set, busy_clr;

    // Ready comes from the registered count only; a full FIFO refuses even while draining.
    assign mem_ready_o = !fifo_full;
    assign mem_fire    = mem_valid_i && mem_ready_o;

`ifdef REG_WRITEBACK_BYPASS_EN
    assign bypass = mem_fire && fifo_empty && !alu_valid_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = mem_fire && !bypass;
    assign pop  = !alu_valid_i && !fifo_empty;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ('{rd: mem_rd_i, data: mem_data_i}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count_o)
    );

    always_comb begin
        wr_d     = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        busy_clr = '0;
        busy_set = issue_valid_i ? (32'd1 << issue_rd_i) : 32'd0;
        if (alu_valid_i) begin
            wr_d   = (alu_rd_i != '0);
            rd_d   = alu_rd_i;
            data_d = alu_data_i;
        end else if (!fifo_empty) begin
            wr_d     = (fifo_head.rd != '0);
            rd_d     = fifo_head.rd;
            data_d   = fifo_head.data;
            busy_clr = 32'd1 << fifo_head.rd;
        end else if (bypass) begin
            wr_d     = (mem_rd_i != '0);
            rd_d     = mem_rd_i;
            data_d   = mem_data_i;
            busy_clr = 32'd1 << mem_rd_i;
        end
        // Set wins over a same-edge clear; x0 is never pending.
        busy_d = ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            busy_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign wb_regwrite_o = wr_q;
    assign wb_rdaddr_o   = rd_q;
    assign wb_rddata_o   = data_q;
    assign busy_o        = busy_q;

endmodule
